mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cache_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter_rr_arbiter_2.sv | 17 +
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the memory arbiter slice.
package cache_pkg;

    // Arbiter FSM: IDLE arbitrates, BURST owns the RAM, RELEASE is a one-cycle gap.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REQ    = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester and RAM signals around the two-way memory arbiter.
// "master" is the arbiter's view (it drives the RAM port); "slave" is the
// view of the surrounding requesters and RAM model.
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 16
);
    import cache_pkg::*;

    // Requester 0
    logic [ADDRESS_WIDTH-1:0] m0_address;
    logic                     m0_rd;
    logic                     m0_wr;
    logic [DATA_WIDTH-1:0]    m0_data_wr;
    logic [DATA_WIDTH-1:0]    m0_data_rd;
    logic                     m0_data_valid;
    logic                     m0_grant;

    // Requester 1
    logic [ADDRESS_WIDTH-1:0] m1_address;
    logic                     m1_rd;
    logic                     m1_wr;
    logic [DATA_WIDTH-1:0]    m1_data_wr;
    logic [DATA_WIDTH-1:0]    m1_data_rd;
    logic                     m1_data_valid;
    logic                     m1_grant;

    // Shared RAM port
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic                     ram_rd;
    logic                     ram_wr;
    logic [DATA_WIDTH-1:0]    ram_data_wr;
    logic [DATA_WIDTH-1:0]    ram_data_rd;
    logic                     ram_data_valid;

    modport master (
        input  m0_address, m0_rd, m0_wr, m0_data_wr,
        output m0_data_rd, m0_data_valid, m0_grant,
        input  m1_address, m1_rd, m1_wr, m1_data_wr,
        output m1_data_rd, m1_data_valid, m1_grant,
        output ram_address, ram_rd, ram_wr, ram_data_wr,
        input  ram_data_rd, ram_data_valid
    );

    modport slave (
        output m0_address, m0_rd, m0_wr, m0_data_wr,
        input  m0_data_rd, m0_data_valid, m0_grant,
        output m1_address, m1_rd, m1_wr, m1_data_wr,
        input  m1_data_rd, m1_data_valid, m1_grant,
        input  ram_address, ram_rd, ram_wr, ram_data_wr,
        output ram_data_rd, ram_data_valid
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter_2.sv
// Two-way round-robin winner pick. A lone requester always wins; under
// contention the requester named by ptr wins. Purely combinational.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner
);

    // Contention defers to the pointer, otherwise the active requester wins.
    always_comb begin
        winner = req[1];
        if (&req) begin
            winner = ptr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester burst arbiter in front of a single RAM port. Ownership is
// held for a whole line burst (BEATS completed beats) or until the owner
// drops its request, followed by a one-cycle release gap.
module mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 16,
    parameter int WORD_OFFSET_WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = '1;

    arb_state_t                   state_reg;
    logic                         grant_id_reg;
    logic                         rr_ptr_reg;
    logic [WORD_OFFSET_WIDTH-1:0] beat_cnt_reg;

    logic [NUM_REQ-1:0]       req_rd;
    logic [NUM_REQ-1:0]       req_wr;
    logic [NUM_REQ-1:0]       req_any;
    logic [ADDRESS_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]    req_wdata [NUM_REQ];
    logic [NUM_REQ-1:0]       grant;
    logic                     winner;
    logic                     in_burst;
    logic                     owner_active;

    assign req_rd       = {bus.m1_rd, bus.m0_rd};
    assign req_wr       = {bus.m1_wr, bus.m0_wr};
    assign req_addr[0]  = bus.m0_address;
    assign req_addr[1]  = bus.m1_address;
    assign req_wdata[0] = bus.m0_data_wr;
    assign req_wdata[1] = bus.m1_data_wr;

    assign in_burst     = (state_reg == BURST);
    assign owner_active = req_any[grant_id_reg];

    // Per-requester request detect and grant decode.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_any[gi] = req_rd[gi] | req_wr[gi];
            assign grant[gi]   = in_burst && (grant_id_reg == 1'(gi));
        end
    endgenerate

    rr_arbiter_2 u_rr (
        .req    (req_any),
        .ptr    (rr_ptr_reg),
        .winner (winner)
    );

    // Arbitration FSM: grab the port, count completed beats, release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_id_reg <= 1'b0;
            rr_ptr_reg   <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (|req_any) begin
                        state_reg    <= BURST;
                        grant_id_reg <= winner;
                        rr_ptr_reg   <= ~winner;
                        beat_cnt_reg <= '0;
                    end
                end
                BURST: begin
                    // A completing beat takes priority over an early drop.
                    if (bus.ram_data_valid) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (beat_cnt_reg == LAST_BEAT) begin
                            state_reg <= RELEASE;
                        end
                    end else if (!owner_active) begin
                        state_reg    <= RELEASE;
                        beat_cnt_reg <= '0;
                    end
                end
                RELEASE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // RAM request mux: follows the owner during a burst, quiet otherwise.
    always_comb begin
        bus.ram_address = '0;
        bus.ram_data_wr = '0;
        bus.ram_rd      = 1'b0;
        bus.ram_wr      = 1'b0;
        if (in_burst) begin
            bus.ram_address = req_addr[grant_id_reg];
            bus.ram_data_wr = req_wdata[grant_id_reg];
            bus.ram_wr      = req_wr[grant_id_reg];
            bus.ram_rd      = req_rd[grant_id_reg] & ~req_wr[grant_id_reg];
        end
    end

    assign bus.m0_grant      = grant[0];
    assign bus.m1_grant      = grant[1];
    assign bus.m0_data_valid = bus.ram_data_valid & grant[0];
    assign bus.m1_data_valid = bus.ram_data_valid & grant[1];
    assign bus.m0_data_rd    = bus.ram_data_rd;
    assign bus.m1_data_rd    = bus.ram_data_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and RAM, all checked every cycle against a
// transaction-level model of bus ownership.
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int WOW   = 2;
    localparam int BEATS = 1 << WOW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

    mem_arbiter #(
        .ADDRESS_WIDTH     (AW),
        .WORD_OFFSET_WIDTH (WOW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, completed beats, release gap, favourite.
    int owner     = -1;
    bit cooldown  = 1'b0;
    int beats     = 0;
    int favoured  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: ownership rules applied to the inputs seen at each edge.
    always @(posedge clk) begin
        bit r0, r1, own_req;
        r0 = bus.m0_rd | bus.m0_wr;
        r1 = bus.m1_rd | bus.m1_wr;
        if (!rst_n) begin
            owner = -1; cooldown = 1'b0; beats = 0; favoured = 0;
        end else if (cooldown) begin
            cooldown = 1'b0;
        end else if (owner < 0) begin
            if (r0 || r1) begin
                owner    = (r0 && r1) ? favoured : (r1 ? 1 : 0);
                favoured = 1 - owner;
                beats    = 0;
            end
        end else begin
            own_req = (owner == 0) ? r0 : r1;
            if (bus.ram_data_valid) begin
                beats++;
                if (beats == BEATS) begin
                    owner = -1; cooldown = 1'b1; beats = 0;
                end
            end else if (!own_req) begin
                owner = -1; cooldown = 1'b1; beats = 0;
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        logic          e_g0, e_g1, e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wd;
        e_g0 = 0; e_g1 = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        if (rst_n && owner >= 0) begin
            e_g0   = (owner == 0);
            e_g1   = (owner == 1);
            e_wr   = e_g0 ? bus.m0_wr : bus.m1_wr;
            e_rd   = (e_g0 ? bus.m0_rd : bus.m1_rd) & ~e_wr;
            e_addr = e_g0 ? bus.m0_address : bus.m1_address;
            e_wd   = e_g0 ? bus.m0_data_wr : bus.m1_data_wr;
        end
        chk("m0_grant", bus.m0_grant, e_g0);
        chk("m1_grant", bus.m1_grant, e_g1);
        chk("grant_exclusive", bus.m0_grant & bus.m1_grant, 0);
        chk("ram_rd", bus.ram_rd, e_rd);
        chk("ram_wr", bus.ram_wr, e_wr);
        chk("ram_address", bus.ram_address, e_addr);
        chk("ram_data_wr", bus.ram_data_wr, e_wd);
        chk("m0_data_valid", bus.m0_data_valid, bus.ram_data_valid & e_g0);
        chk("m1_data_valid", bus.m1_data_valid, bus.ram_data_valid & e_g1);
        chk("m0_data_rd", bus.m0_data_rd, bus.ram_data_rd);
        chk("m1_data_rd", bus.m1_data_rd, bus.ram_data_rd);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m0_address = '0; bus.m0_rd = 0; bus.m0_wr = 0; bus.m0_data_wr = '0;
        bus.m1_address = '0; bus.m1_rd = 0; bus.m1_wr = 0; bus.m1_data_wr = '0;
        bus.ram_data_rd = '0; bus.ram_data_valid = 0;
    endtask

    task automatic set_req(input int x, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [31:0] d);
        if (x == 0) begin
            bus.m0_rd = rd; bus.m0_wr = wr; bus.m0_address = a; bus.m0_data_wr = d;
        end else begin
            bus.m1_rd = rd; bus.m1_wr = wr; bus.m1_address = a; bus.m1_data_wr = d;
        end
    endtask

    bit       act   [2];
    bit       was_g [2];
    bit [1:0] op    [2];

    initial begin
        int vcnt;
        int rst_hold;
        clear_inputs();

        // Reset state: outputs quiet, read data still mirrored.
        bus.m0_rd = 1; bus.ram_data_valid = 1; bus.ram_data_rd = 32'h1234_5678;
        @(negedge clk);
        chk("rst_m0_grant", bus.m0_grant, 0);
        chk("rst_ram_rd", bus.ram_rd, 0);
        chk("rst_m0_valid", bus.m0_data_valid, 0);
        chk("rst_m0_data_rd", bus.m0_data_rd, 32'h1234_5678);
        clear_inputs();

        // Contention straight after reset: m0 first, then m1 writes.
        next_cycle();
        rst_n = 1;
        set_req(0, 1, 0, 16'h0100, 32'h0);
        set_req(1, 0, 1, 16'h2000, 32'hDEAD_BEEF);
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.ram_data_valid = (cyc >= 1 && cyc <= 4);
            if (cyc == 5) bus.m0_rd = 0;
            @(negedge clk);
            chk("cont_m0_grant", bus.m0_grant, (cyc >= 1 && cyc <= 4));
            chk("cont_m1_grant", bus.m1_grant, (cyc >= 7));
            if (cyc == 7) begin
                chk("cont_m1_ram_wr", bus.ram_wr, 1);
                chk("cont_m1_ram_data_wr", bus.ram_data_wr, 32'hDEAD_BEEF);
                chk("cont_m1_ram_address", bus.ram_address, 16'h2000);
            end
            next_cycle();
        end

        // Single read burst with gapped beats on cycles 3,5,6,8.
        clear_inputs();
        rst_n = 0;
        @(negedge clk);
        chk("midrst_m1_grant", bus.m1_grant, 0);
        next_cycle();
        rst_n = 1;
        set_req(0, 1, 0, 16'h0100, 32'h0);
        vcnt = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.ram_data_valid = (cyc == 3 || cyc == 5 || cyc == 6 || cyc == 8);
            if (cyc == 9) bus.m0_rd = 0;
            @(negedge clk);
            chk("burst_m0_grant", bus.m0_grant, (cyc >= 1 && cyc <= 8));
            if (bus.m0_data_valid) vcnt++;
            if (cyc == 1) begin
                chk("burst_ram_address", bus.ram_address, 16'h0100);
                chk("burst_ram_rd", bus.ram_rd, 1);
            end
            next_cycle();
        end
        chk("burst_valid_count", vcnt, 4);

        // Read and write together: the write wins.
        bus.ram_data_valid = 0;
        set_req(1, 1, 1, 16'h0A04, 32'h0000_00A5);
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("rdwr_ram_wr", bus.ram_wr, 1);
        chk("rdwr_ram_rd", bus.ram_rd, 0);
        chk("rdwr_ram_address", bus.ram_address, 16'h0A04);
        next_cycle();
        set_req(1, 0, 0, 16'h0, 32'h0);
        repeat (3) next_cycle();

        // Reset after two beats; the retried burst must run a full four beats.
        set_req(0, 1, 0, 16'h0300, 32'h0);
        bus.ram_data_valid = 1;
        repeat (3) next_cycle();
        rst_n = 0;
        @(negedge clk);
        chk("abort_m0_grant", bus.m0_grant, 0);
        chk("abort_ram_rd", bus.ram_rd, 0);
        next_cycle();
        rst_n = 1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            chk("retry_m0_grant", bus.m0_grant, (cyc >= 1 && cyc <= 4));
            next_cycle();
        end
        clear_inputs();
        repeat (2) next_cycle();

        // Randomized traffic with occasional resets.
        rst_hold = 0;
        for (int x = 0; x < 2; x++) begin
            act[x] = 0; was_g[x] = 0; op[x] = 2'd1;
        end
        for (int n = 0; n < 4000; n++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 0;
                rst_hold = $urandom_range(1, 2);
            end
            for (int x = 0; x < 2; x++) begin
                bit g;
                g = (x == 0) ? bus.m0_grant : bus.m1_grant;
                if (act[x]) begin
                    if (was_g[x] && !g) act[x] = 0;
                    else if (g && $urandom_range(0, 15) == 0) act[x] = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    act[x] = 1;
                    op[x]  = 2'($urandom_range(1, 3));
                end
                was_g[x] = g;
                set_req(x, act[x] & op[x][0], act[x] & op[x][1],
                        AW'($urandom), $urandom);
            end
            bus.ram_data_valid = 1'($urandom_range(0, 1));
            bus.ram_data_rd    = $urandom;
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
